ei_axi4_assertion: RTL and testbench

//  Synthesizable passive AXI4 protocol checker (no ID signals) attached to the monitor view of the bus.

---
 rtl/ei_axi4_assertion_pkg.sv | 53 +++++
 rtl/ei_axi4_assertion_len_fifo.sv | 54 +++++
 rtl/ei_axi4_assertion.sv | 188 ++++++++++++++++++
 tb/tb_ei_axi4_assertion.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ei_axi4_assertion_pkg.sv
// ei_axi4_assertion_pkg
//  Shared definitions for the passive AXI4 protocol checker:
//  burst encodings, error-flag bit positions and small helper functions.
package ei_axi4_assertion_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } axi_burst_e;

    localparam int NUM_ERR       = 18;
    localparam int E_STB_AW      = 0;
    localparam int E_STB_W       = 1;
    localparam int E_STB_B       = 2;
    localparam int E_STB_AR      = 3;
    localparam int E_STB_R       = 4;
    localparam int E_AW_BURST    = 5;
    localparam int E_AR_BURST    = 6;
    localparam int E_AW_SIZE     = 7;
    localparam int E_AR_SIZE     = 8;
    localparam int E_AW_WRAP     = 9;
    localparam int E_AR_WRAP     = 10;
    localparam int E_AW_4K       = 11;
    localparam int E_AR_4K       = 12;
    localparam int E_WLAST       = 13;
    localparam int E_RLAST       = 14;
    localparam int E_W_NO_AW     = 15;
    localparam int E_ORDER       = 16;
    localparam int E_TRK_OVF     = 17;

    // Up/down counter step clamped to 0..255; simultaneous inc and dec cancel.
    function automatic logic [7:0] cnt_step(input logic [7:0] c, input logic inc,
                                            input logic dec);
        logic [7:0] r;
        r = c;
        if (inc && !dec && c != 8'hFF)
            r = c + 8'd1;
        else if (dec && !inc && c != 8'h00)
            r = c - 8'd1;
        return r;
    endfunction

    function automatic logic [4:0] popcnt(input logic [NUM_ERR-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_ERR; i++)
            n = n + {4'd0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/ei_axi4_assertion_len_fifo.sv
// ei_axi4_assertion_len_fifo
//  Small FIFO of burst lengths (awlen/arlen) for outstanding bursts.
//  Ports: clk_i, rst_ni (async low), push_i/data_i, pop_i, data_o (head),
//         full_o, empty_o. Push while full and pop while empty are ignored.
//  DEPTH must be a power of 2.
module ei_axi4_assertion_len_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ei_axi4_assertion.sv
// ei_axi4_assertion
//  Passive AXI4 (no ID) protocol checker on the monitor view of the bus.
//  Never drives the bus; samples all five channels on aclk rising edge.
//  Inputs : aclk, aresetn (async low), AW/W/B/AR/R channel signals.
//  Outputs: err_flags[17:0] registered per-check violations (not sticky),
//           err_any (OR of err_flags), err_count (saturating flag-bit total).
//  Build option: EI_AXI4_ASSERTION_4K_CHK_EN enables the 4KB-crossing
//  checks (bits 11/12); without it those bits are tied to 0.
module ei_axi4_assertion
    import ei_axi4_assertion_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    input  logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    input  logic                rready,
    output logic [17:0]         err_flags,
    output logic                err_any,
    output logic [15:0]         err_count
);
    localparam int STRB_W = DATA_W / 8;
    localparam int AX_PW  = ADDR_W + 13;
    localparam int W_PW   = DATA_W + STRB_W + 1;
    localparam int R_PW   = DATA_W + 3;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    // Stall history and payload snapshot for the stability checks.
    logic [4:0]       stall_d, stall_q;
    logic [AX_PW-1:0] aw_pl, aw_pl_q, ar_pl, ar_pl_q;
    logic [W_PW-1:0]  w_pl, w_pl_q;
    logic [1:0]       b_pl_q;
    logic [R_PW-1:0]  r_pl, r_pl_q;

    assign aw_pl   = {awaddr, awlen, awsize, awburst};
    assign ar_pl   = {araddr, arlen, arsize, arburst};
    assign w_pl    = {wdata, wstrb, wlast};
    assign r_pl    = {rdata, rresp, rlast};
    assign stall_d = {rvalid & ~rready, arvalid & ~arready, bvalid & ~bready,
                      wvalid & ~wready, awvalid & ~awready};

    // Length FIFOs and beat counters.
    logic       aw_push, aw_pop, aw_full, aw_empty;
    logic       ar_push, ar_pop, ar_full, ar_empty;
    logic [7:0] aw_head, ar_head, w_len, r_len;
    logic [7:0] w_cnt_d, w_cnt_q, r_cnt_d, r_cnt_q;
    logic       w_chk, r_chk, w_end, r_end, w_exp_last, r_exp_last;
    logic [7:0] wr_done_d, wr_done_q, rd_out_d, rd_out_q;

    // With an empty FIFO, a same-edge address handshake supplies the length
    // directly. If that beat also closes the burst the entry is never pushed.
    assign w_len      = aw_empty ? awlen : aw_head;
    assign w_chk      = w_hs & (~aw_empty | aw_hs);
    assign w_exp_last = (w_cnt_q == w_len);
    assign w_end      = w_chk & (wlast | w_exp_last);
    assign aw_push    = aw_hs & ~(aw_empty & w_end);
    assign aw_pop     = w_end & ~aw_empty;
    assign w_cnt_d    = w_chk ? (w_end ? 8'd0 : w_cnt_q + 8'd1) : w_cnt_q;

    assign r_len      = ar_empty ? arlen : ar_head;
    assign r_chk      = r_hs & (~ar_empty | ar_hs);
    assign r_exp_last = (r_cnt_q == r_len);
    assign r_end      = r_chk & (rlast | r_exp_last);
    assign ar_push    = ar_hs & ~(ar_empty & r_end);
    assign ar_pop     = r_end & ~ar_empty;
    assign r_cnt_d    = r_chk ? (r_end ? 8'd0 : r_cnt_q + 8'd1) : r_cnt_q;

    assign wr_done_d  = cnt_step(wr_done_q, w_hs & wlast, b_hs);
    assign rd_out_d   = cnt_step(rd_out_q, ar_hs, r_hs & rlast);

    ei_axi4_assertion_len_fifo #(.DEPTH(MAX_OUT), .W(8)) u_aw_fifo (
        .clk_i(aclk), .rst_ni(aresetn), .push_i(aw_push), .data_i(awlen),
        .pop_i(aw_pop), .data_o(aw_head), .full_o(aw_full), .empty_o(aw_empty));

    ei_axi4_assertion_len_fifo #(.DEPTH(MAX_OUT), .W(8)) u_ar_fifo (
        .clk_i(aclk), .rst_ni(aresetn), .push_i(ar_push), .data_i(arlen),
        .pop_i(ar_pop), .data_o(ar_head), .full_o(ar_full), .empty_o(ar_empty));

`ifdef EI_AXI4_ASSERTION_4K_CHK_EN
    function automatic logic cross_4k(input logic [ADDR_W-1:0] addr,
                                      input logic [7:0] len, input logic [2:0] size);
        logic [ADDR_W-1:0] aligned, last;
        aligned = addr & ~((ADDR_W'(1) << size) - ADDR_W'(1));
        last    = aligned + ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        return aligned[ADDR_W-1:12] != last[ADDR_W-1:12];
    endfunction
`endif

    logic [NUM_ERR-1:0] flags_d, flags_q;
    logic [16:0]        cnt_sum;
    logic [15:0]        err_cnt_d, err_cnt_q;

    always_comb begin
        flags_d = '0;
        flags_d[E_STB_AW] = stall_q[0] & (~awvalid | (aw_pl != aw_pl_q));
        flags_d[E_STB_W]  = stall_q[1] & (~wvalid  | (w_pl  != w_pl_q));
        flags_d[E_STB_B]  = stall_q[2] & (~bvalid  | (bresp != b_pl_q));
        flags_d[E_STB_AR] = stall_q[3] & (~arvalid | (ar_pl != ar_pl_q));
        flags_d[E_STB_R]  = stall_q[4] & (~rvalid  | (r_pl  != r_pl_q));
        flags_d[E_AW_BURST] = awvalid & (awburst == BURST_RSVD);
        flags_d[E_AR_BURST] = arvalid & (arburst == BURST_RSVD);
        flags_d[E_AW_SIZE]  = awvalid & ((32'd1 << awsize) > 32'(STRB_W));
        flags_d[E_AR_SIZE]  = arvalid & ((32'd1 << arsize) > 32'(STRB_W));
        flags_d[E_AW_WRAP]  = awvalid & (awburst == BURST_WRAP) &
            ~(awlen == 8'd1 || awlen == 8'd3 || awlen == 8'd7 || awlen == 8'd15);
        flags_d[E_AR_WRAP]  = arvalid & (arburst == BURST_WRAP) &
            ~(arlen == 8'd1 || arlen == 8'd3 || arlen == 8'd7 || arlen == 8'd15);
`ifdef EI_AXI4_ASSERTION_4K_CHK_EN
        flags_d[E_AW_4K] = awvalid & (awburst == BURST_INCR) & cross_4k(awaddr, awlen, awsize);
        flags_d[E_AR_4K] = arvalid & (arburst == BURST_INCR) & cross_4k(araddr, arlen, arsize);
`endif
        flags_d[E_WLAST]   = w_chk & (wlast != w_exp_last);
        flags_d[E_RLAST]   = r_chk & (rlast != r_exp_last);
        flags_d[E_W_NO_AW] = w_hs & aw_empty & ~aw_hs;
        // Registered counts: a completion on the same edge does not qualify.
        flags_d[E_ORDER]   = (bvalid & (wr_done_q == 8'd0)) | (rvalid & (rd_out_q == 8'd0));
        flags_d[E_TRK_OVF] = (aw_hs & aw_full) | (ar_hs & ar_full);
    end

    assign cnt_sum   = {1'b0, err_cnt_q} + 17'(popcnt(flags_d));
    assign err_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_q   <= '0;
            aw_pl_q   <= '0;
            ar_pl_q   <= '0;
            w_pl_q    <= '0;
            b_pl_q    <= '0;
            r_pl_q    <= '0;
            w_cnt_q   <= '0;
            r_cnt_q   <= '0;
            wr_done_q <= '0;
            rd_out_q  <= '0;
            flags_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            stall_q   <= stall_d;
            aw_pl_q   <= aw_pl;
            ar_pl_q   <= ar_pl;
            w_pl_q    <= w_pl;
            b_pl_q    <= bresp;
            r_pl_q    <= r_pl;
            w_cnt_q   <= w_cnt_d;
            r_cnt_q   <= r_cnt_d;
            wr_done_q <= wr_done_d;
            rd_out_q  <= rd_out_d;
            flags_q   <= flags_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_flags = flags_q;
    assign err_any   = |flags_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_ei_axi4_assertion.sv
// tb_ei_axi4_assertion
//  Directed self-checking bench for ei_axi4_assertion (ADDR_W=32, DATA_W=32,
//  MAX_OUT=4). Expected flag/count values are hand-computed per scenario.
//  Honours EI_AXI4_ASSERTION_4K_CHK_EN for the 4KB expectations.
module tb_ei_axi4_assertion;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [17:0] err_flags;
    logic        err_any;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

`ifdef EI_AXI4_ASSERTION_4K_CHK_EN
    localparam logic K4 = 1'b1;
`else
    localparam logic K4 = 1'b0;
`endif

    always #5 aclk = ~aclk;

    ei_axi4_assertion #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .err_flags(err_flags), .err_any(err_any), .err_count(err_count));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [17:0] f, input logic [15:0] c);
        chk({tag, ".flags"}, 32'(err_flags), 32'(f));
        chk({tag, ".any"},   32'(err_any),   32'(|f));
        chk({tag, ".count"}, 32'(err_count), 32'(c));
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1; awvalid = 0; awready = 0;
        wdata = '0; wstrb = 4'hF; wlast = 0; wvalid = 0; wready = 0;
        bresp = '0; bvalid = 0; bready = 0;
        araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1; arvalid = 0; arready = 0;
        rdata = '0; rresp = '0; rlast = 0; rvalid = 0; rready = 0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        idle();
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                      input logic [1:0] b);
        awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1; awready = 1;
    endtask

    task automatic ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                      input logic [1:0] b);
        araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1; arready = 1;
    endtask

    initial begin
        // Reset state
        idle();
        aresetn = 1'b0;
        #1;
        expect_out("rst_async", 18'h0, 16'd0);
        tick(); tick();
        expect_out("rst", 18'h0, 16'd0);
        aresetn = 1'b1;
        tick();
        expect_out("idle", 18'h0, 16'd0);

        // AW address changes while stalled
        awvalid = 1; awready = 0; awaddr = 32'h100;
        tick();
        expect_out("aw_stall", 18'h0, 16'd0);
        awaddr = 32'h104; awready = 1;
        tick();
        expect_out("aw_stable", 18'h1, 16'd1);
        aresetn = 1'b0;
        #1;
        expect_out("rst_clear", 18'h0, 16'd0);
        do_reset();

        // 4KB boundary
        aw(32'hFF0, 8'd3, 3'd2, 2'd1);
        tick();
        expect_out("aw_4k_edge", 18'h0, 16'd0);
        aw(32'hFF4, 8'd3, 3'd2, 2'd1);
        tick();
        expect_out("aw_4k_cross", {6'd0, K4, 11'd0}, K4 ? 16'd1 : 16'd0);
        awvalid = 0; awready = 0;
        ar(32'hFFC, 8'd1, 3'd2, 2'd1);
        tick();
        expect_out("ar_4k_cross", {5'd0, K4, 12'd0}, K4 ? 16'd2 : 16'd0);
        do_reset();

        // WLAST early, then a clean burst
        aw(32'h0, 8'd3, 3'd2, 2'd1);
        tick();
        expect_out("wl_aw", 18'h0, 16'd0);
        awvalid = 0; awready = 0;
        wvalid = 1; wready = 1;
        for (int i = 1; i <= 4; i++) begin
            wdata = 32'(i);
            wlast = (i == 3);
            tick();
            case (i)
                3:       expect_out("wl_beat3", 18'h02000, 16'd1);
                4:       expect_out("wl_beat4_noaw", 18'h08000, 16'd2);
                default: expect_out("wl_beat", 18'h0, 16'd0);
            endcase
        end
        wvalid = 0; wready = 0; wlast = 0;
        aw(32'h40, 8'd1, 3'd2, 2'd1);
        tick();
        awvalid = 0; awready = 0;
        wvalid = 1; wready = 1;
        tick();
        expect_out("wl_ok1", 18'h0, 16'd2);
        wlast = 1;
        tick();
        expect_out("wl_ok2", 18'h0, 16'd2);
        do_reset();

        // Encoding checks
        ar(32'h0, 8'd0, 3'd3, 2'd3);
        tick();
        expect_out("ar_rsvd_size", 18'h00140, 16'd2);
        arvalid = 0; arready = 0;
        aw(32'h0, 8'd2, 3'd2, 2'd2);
        tick();
        expect_out("aw_wrap_len2", 18'h00200, 16'd3);
        aw(32'h0, 8'd3, 3'd2, 2'd2);
        tick();
        expect_out("aw_wrap_len3", 18'h0, 16'd3);
        aw(32'h0, 8'd0, 3'd3, 2'd1);
        tick();
        expect_out("aw_size", 18'h00080, 16'd4);
        do_reset();

        // AR tracking overflow on the fifth outstanding burst
        for (int i = 0; i < 5; i++) begin
            ar(32'(i * 16), 8'd0, 3'd2, 2'd1);
            tick();
            expect_out(i == 4 ? "ar_ovf" : "ar_track", i == 4 ? 18'h20000 : 18'h0,
                       i == 4 ? 16'd1 : 16'd0);
        end
        do_reset();

        // Response ordering against same-edge completion
        aw(32'h0, 8'd0, 3'd2, 2'd1);
        wvalid = 1; wready = 1; wlast = 1;
        bvalid = 1; bready = 0;
        tick();
        expect_out("b_same_edge", 18'h10000, 16'd1);
        awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
        bready = 1;
        tick();
        expect_out("b_next", 18'h0, 16'd1);
        bvalid = 0; bready = 0;
        tick();
        expect_out("b_done", 18'h0, 16'd1);

        // Reset mid read burst
        ar(32'h0, 8'd3, 3'd2, 2'd1);
        tick();
        expect_out("rd_ar", 18'h0, 16'd1);
        arvalid = 0; arready = 0;
        rvalid = 1; rready = 1; rlast = 1; rdata = 32'hA5;
        tick();
        expect_out("rlast_early", 18'h04000, 16'd2);
        aresetn = 1'b0;
        #1;
        expect_out("rst_mid_rd", 18'h0, 16'd0);
        idle();
        tick();
        aresetn = 1'b1;
        rvalid = 1; rready = 1; rlast = 0;
        tick();
        expect_out("r_no_ar", 18'h10000, 16'd1);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
